// File: rtl/muldiv_seq_ctrl_if.sv
// Handshake and data bundle between the issue stage and the iterative
// multiply/divide sequencer. The issuing side uses the master modport and
// the sequencer uses the slave modport.
interface muldiv_seq_ctrl_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      rd_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;

    modport master (
        output start_i, funct3_i, rs1_i, rs2_i, rd_i, flush_i,
        input  stall_o, busy_o, done_o, result_o, rd_o
    );

    modport slave (
        input  start_i, funct3_i, rs1_i, rs2_i, rd_i, flush_i,
        output stall_o, busy_o, done_o, result_o, rd_o
    );
endinterface

// File: rtl/muldiv_seq_ctrl.sv
// Iterative RV32M multiply/divide sequencer.
// Radix-2 shift-add multiply or restoring divide, one bit per cycle over
// XLEN cycles, followed by a sign-fix cycle and a one-cycle done pulse.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for start; operands captured on acceptance
//  CALC   | one multiply/divide iteration per cycle, cnt counts down
//  FIX    | sign correction and result select, result registered
//  DONE   | done_o pulse, result_o/rd_o valid, stall released
module muldiv_seq_ctrl #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    muldiv_seq_ctrl_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   addend_q, addend_d;   // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc_q, acc_d;         // product, or dividend/quotient in low half
    logic [XLEN-1:0]   rem_q, rem_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic              special_q, special_d;
    logic [XLEN-1:0]   spec_res_q, spec_res_d;
    logic [4:0]        rd_cap_q, rd_cap_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_q, rd_d;

    // Operand decode at capture: signedness, magnitudes and special-case results.
    logic            in_is_div, in_a_signed, in_b_signed, in_sa, in_sb;
    logic            in_div0, in_ovf, in_special;
    logic [XLEN-1:0] in_mag_a, in_mag_b, in_spec_res;

    always_comb begin
        in_is_div   = bus.funct3_i[2];
        in_a_signed = in_is_div ? ~bus.funct3_i[0] : (bus.funct3_i != F_MULHU);
        in_b_signed = in_is_div ? ~bus.funct3_i[0]
                                : (bus.funct3_i == F_MUL || bus.funct3_i == F_MULH);
        in_sa       = in_a_signed & bus.rs1_i[XLEN-1];
        in_sb       = in_b_signed & bus.rs2_i[XLEN-1];
        in_mag_a    = in_sa ? -bus.rs1_i : bus.rs1_i;
        in_mag_b    = in_sb ? -bus.rs2_i : bus.rs2_i;
        in_div0     = in_is_div && (bus.rs2_i == '0);
        in_ovf      = in_is_div && ~bus.funct3_i[0]
                      && (bus.rs1_i == INT_MIN) && (bus.rs2_i == '1);
        in_special  = in_div0 | in_ovf;
        // funct3[1] separates REM/REMU from DIV/DIVU
        if (in_div0)
            in_spec_res = bus.funct3_i[1] ? bus.rs1_i : '1;
        else
            in_spec_res = bus.funct3_i[1] ? '0 : bus.rs1_i;
    end

    // One iteration of each datapath plus the sign-fixed result.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]}
                    + (acc_q[0] ? {1'b0, addend_q} : '0);
        div_shift = {rem_q, acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, addend_q};
        prod_fix  = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo_fix   = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix   = sign_a_q ? -rem_q : rem_q;
        if (special_q)
            fix_res = spec_res_q;
        else if (op_q[2])
            fix_res = op_q[1] ? rem_fix : quo_fix;
        else if (op_q == F_MUL)
            fix_res = prod_fix[XLEN-1:0];
        else
            fix_res = prod_fix[2*XLEN-1:XLEN];
    end

    // Sequencer next-state and register updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        addend_d   = addend_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        special_d  = special_q;
        spec_res_d = spec_res_q;
        rd_cap_d   = rd_cap_q;
        result_d   = result_q;
        rd_d       = rd_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.flush_i) begin
                    op_d       = bus.funct3_i;
                    sign_a_d   = in_sa;
                    sign_b_d   = in_sb;
                    special_d  = in_special;
                    spec_res_d = in_spec_res;
                    rd_cap_d   = bus.rd_i;
                    cnt_d      = CW'(XLEN - 1);
                    rem_d      = '0;
                    if (in_is_div) begin
                        addend_d = in_mag_b;
                        acc_d    = {{XLEN{1'b0}}, in_mag_a};
                    end else begin
                        addend_d = in_mag_a;
                        acc_d    = {{XLEN{1'b0}}, in_mag_b};
                    end
                    if (EARLY_OUT && in_special) begin
                        state_d  = S_DONE;
                        result_d = in_spec_res;
                        rd_d     = bus.rd_i;
                    end else begin
                        state_d  = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[2]) begin
                        if (!div_diff[XLEN]) begin
                            rem_d             = div_diff[XLEN-1:0];
                            acc_d[XLEN-1:0]   = {acc_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_d             = div_shift[XLEN-1:0];
                            acc_d[XLEN-1:0]   = {acc_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    if (cnt_q == '0)
                        state_d = S_FIX;
                    else
                        cnt_d = cnt_q - CW'(1);
                end
            end
            S_FIX: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    result_d = fix_res;
                    rd_d     = rd_cap_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            addend_q   <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            rd_cap_q   <= '0;
            result_q   <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addend_q   <= addend_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            special_q  <= special_d;
            spec_res_q <= spec_res_d;
            rd_cap_q   <= rd_cap_d;
            result_q   <= result_d;
            rd_q       <= rd_d;
        end
    end

    // Stall covers the accepting cycle so the issuing stage holds immediately.
    always_comb begin
        bus.stall_o  = ((state_q == S_IDLE) && bus.start_i && !bus.flush_i)
                       || (state_q == S_CALC) || (state_q == S_FIX);
        bus.busy_o   = (state_q != S_IDLE);
        bus.done_o   = (state_q == S_DONE);
        bus.result_o = result_q;
        bus.rd_o     = rd_q;
    end
endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Self-checking bench for muldiv_seq_ctrl: directed corner cases, flush,
// mid-op reset, and randomized ops against an arithmetic reference model.
module tb_muldiv_seq_ctrl;
    localparam int XLEN      = 32;
    localparam bit EARLY_OUT = 1'b1;
    localparam int FULL_LAT  = XLEN + 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    muldiv_seq_ctrl_if #(.XLEN(XLEN)) bus ();

    muldiv_seq_ctrl #(.XLEN(XLEN), .EARLY_OUT(EARLY_OUT)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, p;
        logic [63:0] up;
        int          ia, ib;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ia = signed'(a);
        ib = signed'(b);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
            3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        logic special;
        special = f[2] && ((b == 32'h0) ||
                  (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return (EARLY_OUT && special) ? 1 : FULL_LAT;
    endfunction

    // Launch an op at the current falling edge and follow it to completion.
    // pulse_cyc > 0 re-asserts start with a different op mid-flight.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input int pulse_cyc);
        int   cyc;
        int   stall_bad;
        logic d, s;
        bus.start_i  = 1'b1;
        bus.funct3_i = f;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        bus.rd_i     = rd;
        #1;
        stall_bad = (bus.stall_o === 1'b1) ? 0 : 1;
        cyc = 0;
        d = 1'b0;
        s = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            d = bus.done_o;
            s = bus.stall_o;
            if (d !== 1'b1 && s !== 1'b1) stall_bad++;
            bus.start_i = (cyc == pulse_cyc);
            if (cyc == pulse_cyc) begin
                bus.funct3_i = 3'd5;
                bus.rs1_i    = 32'd5;
                bus.rs2_i    = 32'd0;
                bus.rd_i     = 5'd31;
            end
        end while (d !== 1'b1 && cyc < 60);
        bus.start_i = 1'b0;
        check({tag, "_lat"}, 32'(cyc), 32'(ref_lat(f, a, b)));
        check({tag, "_res"}, bus.result_o, ref_res(f, a, b));
        check({tag, "_rd"}, 32'(bus.rd_o), 32'(rd));
        check({tag, "_stall_busy"}, 32'(stall_bad), 32'd0);
        check({tag, "_stall_done"}, 32'(s), 32'd0);
        @(negedge clk);
        check({tag, "_pulse_end"}, {30'h0, bus.done_o, bus.busy_o}, 32'd0);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] prior;
        int          done_seen;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.start_i  = 1'b0;
        bus.funct3_i = 3'd0;
        bus.rs1_i    = '0;
        bus.rs2_i    = '0;
        bus.rd_i     = '0;
        bus.flush_i  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {29'h0, bus.stall_o, bus.busy_o, bus.done_o}, 32'd0);
        check("reset_data", bus.result_o ^ {27'h0, bus.rd_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul_7_m3",    3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  0);
        run_op("mulh_min",    3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  0);
        run_op("mulhu_min",   3'd3, 32'h8000_0000, 32'h8000_0000, 5'd7,  0);
        run_op("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF, 32'd2,        5'd8,  0);
        run_op("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  0);
        run_op("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        run_op("divu_by0",    3'd5, 32'd5,        32'd0,         5'd11, 0);
        run_op("rem_by0",     3'd6, 32'hFFFF_FFF9, 32'd0,        5'd12, 0);
        run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2,        5'd13, 0);
        run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2,        5'd14, 0);
        run_op("divu_100_7",  3'd5, 32'd100,      32'd7,         5'd15, 0);
        run_op("remu_100_7",  3'd7, 32'd100,      32'd7,         5'd16, 0);
        run_op("mul_start_ignored", 3'd0, 32'd7,  32'hFFFF_FFFD, 5'd17, 5);

        // Flush during CALC: no done, result held, restart next cycle.
        prior = bus.result_o;
        done_seen = 0;
        bus.start_i  = 1'b1;
        bus.funct3_i = 3'd4;
        bus.rs1_i    = 32'd1000;
        bus.rs2_i    = 32'd3;
        bus.rd_i     = 5'd20;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) done_seen++;
            bus.start_i = 1'b0;
            bus.flush_i = (c == 10);
        end
        check("flush_busy", 32'(bus.busy_o), 32'd0);
        check("flush_no_done", 32'(done_seen), 32'd0);
        check("flush_result_held", bus.result_o, prior);
        run_op("after_flush_divu", 3'd5, 32'd100, 32'd7, 5'd21, 0);

        // Flush and start together in IDLE: start is dropped.
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.funct3_i = 3'd0;
        #1;
        check("flush_start_stall", 32'(bus.stall_o), 32'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        check("flush_start_busy", 32'(bus.busy_o), 32'd0);

        // Reset in the middle of a multiply.
        bus.start_i  = 1'b1;
        bus.funct3_i = 3'd0;
        bus.rs1_i    = 32'd3;
        bus.rs2_i    = 32'd5;
        bus.rd_i     = 5'd22;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            rst_n = (c != 20);
        end
        check("midreset_ctrl", {29'h0, bus.stall_o, bus.busy_o, bus.done_o}, 32'd0);
        check("midreset_result", bus.result_o, 32'd0);
        check("midreset_rd", 32'(bus.rd_o), 32'd0);
        run_op("after_reset_mul", 3'd0, 32'd3, 32'd5, 5'd23, 0);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = rand_operand();
            rb = rand_operand();
            run_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, 5'($urandom_range(0, 31)), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
